sprite_line_loader: RTL and testbench

//  Producer end of the sprite_file load handshake. On each line start, scans OAM in index

---
 rtl/sprite_defines.sv | 41 ++++
 rtl/sprite_hit_check.sv | 28 ++
 rtl/sprite_line_loader.sv | 177 +++++++++++++++++
 tb/tb_sprite_line_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_defines.sv
// Shared types for the sprite line loader: OAM entry and sprite_file record layouts,
// sizing constants and the loader state encoding (OVF_SCAN only with SPRITE_OVERFLOW_EN).
package sprite_defines;

   localparam int MAX_SPRITES_PER_LINE = 16;
   localparam int DEF_OAM_ENTRIES      = 64;

   typedef struct packed {
      logic [7:0] y;
      logic [8:0] x;
      logic [9:0] tile;
      logic       tall;
      logic       hflip;
      logic       vflip;
      logic [1:0] prio;
      logic [2:0] pal;
   } sprite_oam_t;

   typedef struct packed {
      logic [8:0]  x;
      logic [1:0]  prio;
      logic [2:0]  pal;
      logic        hflip;
      logic [31:0] pattern;
   } sprite_reg_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_OAM_RD,
      S_OAM_CHK,
      S_VRAM_RD,
      S_VRAM_WAIT,
      S_PUSH,
      S_DONE
`ifdef SPRITE_OVERFLOW_EN
      ,
      S_OVF_SCAN
`endif
   } load_state_t;

endpackage

// File: rtl/sprite_hit_check.sv
// Combinational scanline hit test for one OAM entry: decides coverage of `row` and
// produces the pattern row index, with vertical flip applied.
module sprite_hit_check (
   input  logic [7:0] y,
   input  logic [7:0] row,
   input  logic       tall,
   input  logic       vflip,
   input  logic [1:0] prio,
   output logic       hit,
   output logic [3:0] line
);

   logic [7:0] diff;
   logic [7:0] height;

   always_comb begin
      // modulo-256 subtraction makes sprites straddling y=255 wrap onto the top lines
      diff   = row - y;
      height = tall ? 8'd16 : 8'd8;
      hit    = (prio != 2'd0) && (diff < height);
      if (tall) begin
         line = vflip ? (4'd15 - diff[3:0]) : diff[3:0];
      end else begin
         line = vflip ? {1'b0, 3'd7 - diff[2:0]} : {1'b0, diff[2:0]};
      end
   end

endmodule

// File: rtl/sprite_line_loader.sv
// Per-scanline OAM scan and pattern fetch feeding sprite_file over a valid/ack handshake.
// Optional SPRITE_OVERFLOW_EN keeps scanning after the record limit to flag overflow.
module sprite_line_loader
   import sprite_defines::*;
#(
   parameter int SPRITES     = MAX_SPRITES_PER_LINE,
   parameter int OAM_ENTRIES = DEF_OAM_ENTRIES
) (
   input  logic        clock,
   input  logic        reset_l,
   input  logic        start,
   input  logic [7:0]  row,
   output logic        sf_clear,
   output logic [5:0]  oam_addr,
   input  sprite_oam_t oam_data,
   output logic [13:0] vram_addr,
   input  logic [31:0] vram_data,
   output sprite_reg_t out,
   output logic        out_valid,
   input  logic        out_ack,
   output logic        done,
   output logic        overflow
);

   localparam int               CNT_W    = $clog2(SPRITES + 1);
   localparam logic [5:0]       LAST_IDX = 6'(OAM_ENTRIES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SPRITES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SPRITES - 1);

   load_state_t      state, state_n;
   logic [5:0]       idx;
   logic [CNT_W-1:0] count;
   logic [7:0]       row_q;
   logic             hit;
   logic [3:0]       line;
   logic             idx_clr, idx_inc, ld_attr, ld_pat, cnt_inc;

   sprite_hit_check u_hit (
      .y     (oam_data.y),
      .row   (row_q),
      .tall  (oam_data.tall),
      .vflip (oam_data.vflip),
      .prio  (oam_data.prio),
      .hit   (hit),
      .line  (line)
   );

   assign oam_addr  = idx;
   assign out_valid = (state == S_PUSH);

`ifdef SPRITE_OVERFLOW_EN
   logic ovf_set;
   logic full;
   assign full = (count == CNT_MAX);
`endif

   always_ff @(posedge clock) begin
      if (!reset_l) state <= S_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n  = state;
      sf_clear = 1'b0;
      done     = 1'b0;
      idx_clr  = 1'b0;
      idx_inc  = 1'b0;
      ld_attr  = 1'b0;
      ld_pat   = 1'b0;
      cnt_inc  = 1'b0;
`ifdef SPRITE_OVERFLOW_EN
      ovf_set  = 1'b0;
`endif
      // start overrides everything, including a transfer in the same cycle
      if (start) begin
         sf_clear = 1'b1;
         idx_clr  = 1'b1;
         state_n  = S_OAM_RD;
      end else begin
         case (state)
`ifdef SPRITE_OVERFLOW_EN
            S_OAM_RD: state_n = full ? S_OVF_SCAN : S_OAM_CHK;
`else
            S_OAM_RD: state_n = S_OAM_CHK;
`endif
            S_OAM_CHK: begin
               if (hit) begin
                  ld_attr = 1'b1;
                  state_n = S_VRAM_RD;
               end else if (idx == LAST_IDX) begin
                  state_n = S_DONE;
               end else begin
                  idx_inc = 1'b1;
                  state_n = S_OAM_RD;
               end
            end
            S_VRAM_RD: state_n = S_VRAM_WAIT;
            S_VRAM_WAIT: begin
               ld_pat  = 1'b1;
               state_n = S_PUSH;
            end
            S_PUSH: begin
               if (out_ack) begin
                  cnt_inc = 1'b1;
`ifdef SPRITE_OVERFLOW_EN
                  if (idx == LAST_IDX) begin
`else
                  if ((idx == LAST_IDX) || (count == LAST_CNT)) begin
`endif
                     state_n = S_DONE;
                  end else begin
                     idx_inc = 1'b1;
                     state_n = S_OAM_RD;
                  end
               end
            end
            S_DONE: begin
               done    = 1'b1;
               state_n = S_IDLE;
            end
`ifdef SPRITE_OVERFLOW_EN
            S_OVF_SCAN: begin
               if (hit) begin
                  ovf_set = 1'b1;
                  state_n = S_DONE;
               end else if (idx == LAST_IDX) begin
                  state_n = S_DONE;
               end else begin
                  idx_inc = 1'b1;
                  state_n = S_OAM_RD;
               end
            end
`endif
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_l) begin
         idx       <= '0;
         count     <= '0;
         row_q     <= '0;
         vram_addr <= '0;
         out       <= '0;
      end else begin
         if (idx_clr) begin
            idx   <= '0;
            count <= '0;
            row_q <= row;
         end else begin
            if (idx_inc) idx <= idx + 1'b1;
            if (cnt_inc && (count != CNT_MAX)) count <= count + 1'b1;
         end
         // attributes captured while oam_data is valid; pattern follows two cycles later
         if (ld_attr) begin
            vram_addr <= {oam_data.tile, line};
            out.x     <= oam_data.x;
            out.prio  <= oam_data.prio;
            out.pal   <= oam_data.pal;
            out.hflip <= oam_data.hflip;
         end
         if (ld_pat) out.pattern <= vram_data;
      end
   end

`ifdef SPRITE_OVERFLOW_EN
   always_ff @(posedge clock) begin
      if (!reset_l)     overflow <= 1'b0;
      else if (idx_clr) overflow <= 1'b0;
      else if (ovf_set) overflow <= 1'b1;
   end
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_line_loader.sv
// Randomized bench for sprite_line_loader with a queue-based per-line reference model.
`timescale 1ns/1ps
module tb_sprite_line_loader;
   import sprite_defines::*;

   logic        clock = 1'b0;
   logic        reset_l, start, out_ack;
   logic [7:0]  row;
   logic        sf_clear, out_valid, done, overflow;
   logic [5:0]  oam_addr;
   logic [13:0] vram_addr;
   logic [31:0] vram_data;
   sprite_oam_t oam_data;
   sprite_reg_t out;

   sprite_oam_t oam_mem [64];
   sprite_reg_t exp_rec [$];
   logic [13:0] exp_vaddr [$];
   int          exp_hits;
   int          n_cmp = 0;
   int          n_err = 0;

   sprite_line_loader dut (
      .clock     (clock),
      .reset_l   (reset_l),
      .start     (start),
      .row       (row),
      .sf_clear  (sf_clear),
      .oam_addr  (oam_addr),
      .oam_data  (oam_data),
      .vram_addr (vram_addr),
      .vram_data (vram_data),
      .out       (out),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .done      (done),
      .overflow  (overflow)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] pat_of(input logic [13:0] a);
      return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   always @(posedge clock) begin
      oam_data  <= oam_mem[oam_addr];
      vram_data <= pat_of(vram_addr);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic sprite_oam_t mk(input int y, input int x, input int tile, input bit tall,
                                      input bit hflip, input bit vflip, input int prio, input int pal);
      sprite_oam_t e;
      e.y = 8'(y); e.x = 9'(x); e.tile = 10'(tile); e.tall = tall; e.hflip = hflip;
      e.vflip = vflip; e.prio = 2'(prio); e.pal = 3'(pal);
      return e;
   endfunction

   // Reference: first MAX_SPRITES_PER_LINE covering entries in index order.
   function automatic void build_expect(input int r);
      exp_rec.delete();
      exp_vaddr.delete();
      exp_hits = 0;
      for (int i = 0; i < 64; i++) begin
         int diff, h, ln;
         sprite_reg_t rec;
         logic [13:0] va;
         diff = (r - int'(oam_mem[i].y) + 256) % 256;
         h    = oam_mem[i].tall ? 16 : 8;
         if (oam_mem[i].prio != 2'd0 && diff < h) begin
            exp_hits++;
            if (exp_rec.size() < MAX_SPRITES_PER_LINE) begin
               ln          = oam_mem[i].vflip ? (h - 1 - diff) : diff;
               va          = {oam_mem[i].tile, 4'(ln)};
               rec.x       = oam_mem[i].x;
               rec.prio    = oam_mem[i].prio;
               rec.pal     = oam_mem[i].pal;
               rec.hflip   = oam_mem[i].hflip;
               rec.pattern = pat_of(va);
               exp_rec.push_back(rec);
               exp_vaddr.push_back(va);
            end
         end
      end
   endfunction

   task automatic clear_oam();
      for (int i = 0; i < 64; i++)
         oam_mem[i] = mk($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 0, $urandom);
   endtask

   task automatic fill_oam(input int r, input int pct);
      for (int i = 0; i < 64; i++) begin
         sprite_oam_t e;
         e = mk($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom);
         if (int'($urandom_range(99)) < pct) begin
            e.prio = 2'($urandom_range(3, 1));
            e.y    = 8'(r - int'($urandom_range(e.tall ? 15 : 7)));
         end
         oam_mem[i] = e;
      end
   endtask

   // Called at a negedge; returns at the negedge of the first busy cycle.
   task automatic launch(input logic [7:0] r);
      row   = r;
      start = 1'b1;
      #1 chk("sf_clear_on_start", 64'(sf_clear), 64'd1);
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic monitor(input int ack_mode, output int done_cyc);
      int          wait_cnt, pushes, exp_n;
      bit          hold, got_done, a;
      logic        exp_ovf;
      sprite_reg_t prev;
      wait_cnt = 0; pushes = 0; hold = 0; got_done = 0; prev = '0;
      exp_n    = exp_rec.size();
      done_cyc = -1;
`ifdef SPRITE_OVERFLOW_EN
      exp_ovf = (exp_hits > MAX_SPRITES_PER_LINE);
`else
      exp_ovf = 1'b0;
`endif
      for (int cyc = 1; cyc <= 4000 && !got_done; cyc++) begin
         if (cyc > 1) @(negedge clock);
         if (hold) begin
            chk("valid_held", 64'(out_valid), 64'd1);
            chk("out_stable", 64'(out), 64'(prev));
         end
         hold = 0;
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
            out_ack  = 1'b0;
         end else if (out_valid) begin
            case (ack_mode)
               0:       a = 1'($urandom);
               1:       a = (wait_cnt >= 5);
               default: a = 1'b1;
            endcase
            out_ack = a;
            if (a) begin
               pushes++;
               wait_cnt = 0;
               if (exp_rec.size() == 0) begin
                  chk("extra_push", 64'(pushes), 64'(exp_n));
               end else begin
                  chk("record", 64'(out), 64'(exp_rec.pop_front()));
                  chk("vram_addr", 64'(vram_addr), 64'(exp_vaddr.pop_front()));
               end
            end else begin
               wait_cnt++;
               hold = 1;
               prev = out;
            end
         end else begin
            out_ack = 1'($urandom);
         end
      end
      chk("done_seen", 64'(got_done), 64'd1);
      if (got_done) begin
         chk("push_count", 64'(pushes), 64'(exp_n));
         chk("overflow", 64'(overflow), 64'(exp_ovf));
         @(negedge clock);
         chk("done_pulse", 64'(done), 64'd0);
         chk("overflow_held", 64'(overflow), 64'(exp_ovf));
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_done"},      64'(done),      64'd0);
      chk({tag, "_sf_clear"},  64'(sf_clear),  64'd0);
      chk({tag, "_overflow"},  64'(overflow),  64'd0);
      chk({tag, "_oam_addr"},  64'(oam_addr),  64'd0);
      chk({tag, "_vram_addr"}, 64'(vram_addr), 64'd0);
      chk({tag, "_out"},       64'(out),       64'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int dc;
      logic [7:0] r;
      reset_l = 1'b0; start = 1'b0; out_ack = 1'b0; row = 8'd0;
      clear_oam();
      repeat (3) @(negedge clock);
      chk_all_zero("reset");
      reset_l = 1'b1;
      @(negedge clock);

      // no sprite has nonzero priority
      clear_oam();
      build_expect(10);
      launch(8'd10);
      monitor(2, dc);
      chk("done_cycle_zero_hits", 64'(dc), 64'd129);

      // single short sprite at index 5
      clear_oam();
      oam_mem[5] = mk(10, 77, 'h12, 0, 1, 0, 2, 5);
      build_expect(13);
      launch(8'd13);
      monitor(2, dc);
      chk("vram_addr_single", 64'(vram_addr), 64'h123);

      // tall, vflipped, wrapping past y=255
      clear_oam();
      oam_mem[9] = mk(250, 3, 'h2A5, 1, 0, 1, 1, 2);
      build_expect(2);
      launch(8'd2);
      monitor(0, dc);
      chk("vram_line_vflip_wrap", 64'(vram_addr[3:0]), 64'd7);

      // 20 hits with slow acknowledge
      clear_oam();
      for (int i = 0; i < 60; i += 3) begin
         bit t;
         t = 1'($urandom);
         oam_mem[i] = mk(100 - int'($urandom_range(t ? 15 : 7)), $urandom, $urandom, t,
                         1'($urandom), 1'($urandom), $urandom_range(3, 1), $urandom);
      end
      build_expect(100);
      launch(8'd100);
      monitor(1, dc);

      // random lines
      for (int k = 0; k < 6; k++) begin
         r = 8'($urandom);
         fill_oam(r, int'($urandom_range(45)));
         build_expect(r);
         launch(r);
         monitor(0, dc);
      end

      // restart while a record waits, with ack coinciding with start
      r = 8'($urandom);
      fill_oam(r, 50);
      oam_mem[0] = mk(r, 1, 'h3C, 0, 0, 0, 3, 1);
      build_expect(r);
      out_ack = 1'b0;
      launch(r);
      for (int c = 0; c < 200 && !out_valid; c++) @(negedge clock);
      chk("midpush_valid_seen", 64'(out_valid), 64'd1);
      out_ack = 1'b1;
      launch(r);
      chk("valid_drop_after_start", 64'(out_valid), 64'd0);
      monitor(0, dc);

      // reset while the pattern fetch is outstanding
      clear_oam();
      oam_mem[0] = mk(40, 9, 'h155, 0, 0, 0, 1, 4);
      out_ack = 1'b0;
      launch(8'd40);
      repeat (3) @(negedge clock);
      reset_l = 1'b0;
      @(negedge clock);
      chk_all_zero("mid_reset");
      reset_l = 1'b1;
      @(negedge clock);
      build_expect(40);
      launch(8'd40);
      monitor(2, dc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
